run_length_encoder: RTL and testbench

// - Per-channel JPEG run-length/category encoder sitting directly downstream of each Quantizer channel.
// - Consumes 64 quantized coefficients per 8x8 block in zigzag order.
// - Emits Huffman-ready symbols (run, size, amplitude): one DC-difference symbol, AC symbols, ZRL and EOB.
// - One instance per colour channel; DC predictor is private to the instance.

---
 rtl/run_length_encoder.sv | 236 +++++++++++++++++++++++
 tb/tb_run_length_encoder.sv | 474 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_length_encoder.sv
// -----------------------------------------------------------------------------
// run_length_encoder
//
// Per-channel JPEG run-length / category encoder. It takes 64 quantized
// coefficients per 8x8 block in zigzag order and emits Huffman-ready symbols:
// one DC-difference symbol per block, AC (run,size,amp) symbols, ZRL (15,0)
// and EOB (0,0). The DC predictor is private to this instance.
//
// Ports
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   in_valid      coefficient present on in_data
//   in_ready      encoder accepts the coefficient this cycle
//   in_data       signed quantized coefficient (zigzag index 0 = DC .. 63)
//   out_valid     symbol present on out_* (held until out_ready)
//   out_ready     downstream accepts the symbol
//   out_run       preceding zero run (0 for DC/EOB, 15 for ZRL)
//   out_size      magnitude category
//   out_amp       amplitude bits, right-aligned, upper bits zero
//   out_is_dc     symbol is the DC difference
//   out_eob       symbol is End-Of-Block
//   dbg_state_o   current FSM state (ACCEPT/ZRL/SYM)
//
// Handshake: on both sides a transfer happens on a rising edge where valid and
// ready are both high. valid never depends on ready; once out_valid is high the
// out_* fields stay frozen until the cycle in which out_ready is seen high.
// in_ready is high only in ACCEPT with a free output slot, so every accepted
// coefficient that produces a symbol can load the output register directly.
// -----------------------------------------------------------------------------
module run_length_encoder #(
  parameter int DATA_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            out_run,
  output logic [3:0]            out_size,
  output logic [DATA_WIDTH:0]   out_amp,
  output logic                  out_is_dc,
  output logic                  out_eob,
  output logic [1:0]            dbg_state_o
);

  localparam int AW = DATA_WIDTH + 1;

  typedef enum logic [1:0] {
    S_ACCEPT = 2'd0,
    S_ZRL    = 2'd1,
    S_SYM    = 2'd2
  } state_e;

  // Bit length of |x|; x is AW-bit two's complement. The negation is read as
  // unsigned, so even the most-negative AW-bit value yields its true magnitude.
  function automatic logic [3:0] calc_cat(input logic [AW-1:0] x);
    logic [AW-1:0] mag;
    logic [3:0]    cat;
    mag = x[AW-1] ? (~x + AW'(1)) : x;
    cat = 4'd0;
    for (int i = 0; i < AW; i++) begin
      if (mag[i]) cat = 4'(i + 1);
    end
    return cat;
  endfunction

  // Positive values are sent as-is; negative values as the low 'cat' bits of
  // x-1 (ones-complement form), with everything above them forced to zero.
  function automatic logic [AW-1:0] calc_amp(input logic [AW-1:0] x,
                                             input logic [3:0]    cat);
    logic [AW-1:0] mask;
    mask = (AW'(1) << cat) - AW'(1);
    return x[AW-1] ? ((x - AW'(1)) & mask) : x;
  endfunction

  state_e                state_q, state_d;
  logic [5:0]            idx_q, idx_d;
  logic [5:0]            zero_run_q, zero_run_d;
  logic [DATA_WIDTH-1:0] dc_pred_q, dc_pred_d;
  logic [DATA_WIDTH-1:0] lat_q, lat_d;
  logic                  ready_en_q;

  logic                  out_valid_q;
  logic [3:0]            out_run_q;
  logic [3:0]            out_size_q;
  logic [AW-1:0]         out_amp_q;
  logic                  out_is_dc_q;
  logic                  out_eob_q;

  logic                  slot_free;
  logic                  accept;
  logic [AW-1:0]         in_ext;
  logic [AW-1:0]         lat_ext;
  logic [AW-1:0]         dc_diff;

  // Symbol being produced this cycle. ZRL and EOB use sym_val = 0, which
  // naturally gives size 0 and amp 0 from the shared category logic.
  logic                  emit;
  logic [3:0]            sym_run;
  logic [AW-1:0]         sym_val;
  logic                  sym_is_dc;
  logic                  sym_eob;
  logic [3:0]            sym_cat;
  logic [AW-1:0]         sym_amp;

  assign slot_free = !out_valid_q || out_ready;
  // ready_en_q keeps in_ready low through the reset cycle.
  assign in_ready  = ready_en_q && (state_q == S_ACCEPT) && slot_free;
  assign accept    = in_valid && in_ready;

  assign in_ext  = {in_data[DATA_WIDTH-1], in_data};
  assign lat_ext = {lat_q[DATA_WIDTH-1], lat_q};
  assign dc_diff = in_ext - {dc_pred_q[DATA_WIDTH-1], dc_pred_q};

  assign sym_cat = calc_cat(sym_val);
  assign sym_amp = calc_amp(sym_val, sym_cat);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    zero_run_d = zero_run_q;
    dc_pred_d  = dc_pred_q;
    lat_d      = lat_q;
    emit       = 1'b0;
    sym_run    = 4'd0;
    sym_val    = '0;
    sym_is_dc  = 1'b0;
    sym_eob    = 1'b0;

    case (state_q)
      S_ACCEPT: begin
        if (accept) begin
          idx_d = idx_q + 6'd1;
          if (idx_q == 6'd0) begin
            // DC: always emitted, even for a zero difference.
            emit       = 1'b1;
            sym_val    = dc_diff;
            sym_is_dc  = 1'b1;
            dc_pred_d  = in_data;
            zero_run_d = 6'd0;
          end else if (in_data == '0) begin
            if (idx_q == 6'd63) begin
              // Trailing zeros collapse into EOB; no ZRL for them.
              emit       = 1'b1;
              sym_eob    = 1'b1;
              zero_run_d = 6'd0;
            end else begin
              zero_run_d = zero_run_q + 6'd1;
            end
          end else if (zero_run_q < 6'd16) begin
            emit       = 1'b1;
            sym_run    = zero_run_q[3:0];
            sym_val    = in_ext;
            zero_run_d = 6'd0;
          end else begin
            // Run too long for one symbol: hold the coefficient and emit
            // ZRLs first.
            lat_d   = in_data;
            state_d = S_ZRL;
          end
        end
      end

      S_ZRL: begin
        if (slot_free) begin
          emit       = 1'b1;
          sym_run    = 4'd15;
          zero_run_d = zero_run_q - 6'd16;
          if (zero_run_q < 6'd32) state_d = S_SYM;
        end
      end

      S_SYM: begin
        if (slot_free) begin
          emit       = 1'b1;
          sym_run    = zero_run_q[3:0];
          sym_val    = lat_ext;
          zero_run_d = 6'd0;
          state_d    = S_ACCEPT;
        end
      end

      default: state_d = S_ACCEPT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_ACCEPT;
      idx_q      <= 6'd0;
      zero_run_q <= 6'd0;
      dc_pred_q  <= '0;
      lat_q      <= '0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      zero_run_q <= zero_run_d;
      dc_pred_q  <= dc_pred_d;
      lat_q      <= lat_d;
      ready_en_q <= 1'b1;
    end
  end

  // Output register: loads only when the slot is free, so a stalled symbol is
  // never overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_run_q   <= 4'd0;
      out_size_q  <= 4'd0;
      out_amp_q   <= '0;
      out_is_dc_q <= 1'b0;
      out_eob_q   <= 1'b0;
    end else if (emit) begin
      out_valid_q <= 1'b1;
      out_run_q   <= sym_run;
      out_size_q  <= sym_cat;
      out_amp_q   <= sym_amp;
      out_is_dc_q <= sym_is_dc;
      out_eob_q   <= sym_eob;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_run     = out_run_q;
  assign out_size    = out_size_q;
  assign out_amp     = out_amp_q;
  assign out_is_dc   = out_is_dc_q;
  assign out_eob     = out_eob_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_run_length_encoder.sv
// -----------------------------------------------------------------------------
// Testbench for run_length_encoder: directed JPEG blocks with hand-computed
// symbols, then random blocks checked against a block-level reference model.
// -----------------------------------------------------------------------------
module tb_run_length_encoder;

  localparam int DW = 10;
  localparam int AW = DW + 1;
  localparam int SW = AW + 10;  // {is_dc, eob, run[3:0], size[3:0], amp}

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [3:0]    out_run;
  logic [3:0]    out_size;
  logic [AW-1:0] out_amp;
  logic          out_is_dc;
  logic          out_eob;
  logic [1:0]    dbg_state;

  run_length_encoder #(.DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_run     (out_run),
    .out_size    (out_size),
    .out_amp     (out_amp),
    .out_is_dc   (out_is_dc),
    .out_eob     (out_eob),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int            n_cmp = 0;
  int            n_fail = 0;
  int            n_sym = 0;
  logic [SW-1:0] exp_q[$];
  int            pred_tb = 0;
  int            rdy_mode = 0;  // 0 always, 1 stall 5/symbol, 2 random, 3 hold low
  int            stall_cnt = 0;
  logic [SW-1:0] held;
  bit            held_valid = 1'b0;
  logic [1:0]    idle_state;

  function automatic logic [SW-1:0] mk_sym(bit dc, bit eob, int run, int size, int amp);
    return {dc, eob, 4'(run), 4'(size), AW'(amp)};
  endfunction

  // ---------------- reference model ----------------
  function automatic int ref_cat(int x);
    int a;
    int n;
    a = (x < 0) ? -x : x;
    n = 0;
    while (a > 0) begin
      n++;
      a = a >> 1;
    end
    return n;
  endfunction

  function automatic int ref_amp(int x);
    int n;
    n = ref_cat(x);
    return (x >= 0) ? x : x + (1 << n) - 1;
  endfunction

  task automatic model_block(input int c[64]);
    int diff;
    int run;
    diff = c[0] - pred_tb;
    exp_q.push_back(mk_sym(1'b1, 1'b0, 0, ref_cat(diff), ref_amp(diff)));
    pred_tb = c[0];
    run = 0;
    for (int k = 1; k < 64; k++) begin
      if (c[k] == 0) begin
        if (k == 63) exp_q.push_back(mk_sym(1'b0, 1'b1, 0, 0, 0));
        else run++;
      end else begin
        while (run >= 16) begin
          exp_q.push_back(mk_sym(1'b0, 1'b0, 15, 0, 0));
          run -= 16;
        end
        exp_q.push_back(mk_sym(1'b0, 1'b0, run, ref_cat(c[k]), ref_amp(c[k])));
        run = 0;
      end
    end
  endtask

  // ---------------- output monitor / scoreboard ----------------
  initial begin
    logic [SW-1:0] obs;
    logic [SW-1:0] exp;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: begin
          if (out_valid) begin
            if (stall_cnt < 5) begin
              out_ready = 1'b0;
              stall_cnt++;
            end else begin
              out_ready = 1'b1;
              stall_cnt = 0;
            end
          end else begin
            out_ready = 1'b0;
          end
        end
        2: out_ready = ($urandom_range(0, 7) != 0);
        default: out_ready = 1'b0;
      endcase
      @(negedge clk);
      if (!rst_n) begin
        held_valid = 1'b0;
      end else if (out_valid) begin
        obs = {out_is_dc, out_eob, out_run, out_size, out_amp};
        if (held_valid) begin
          n_cmp++;
          if (obs !== held) begin
            n_fail++;
            $display("FAIL stall_stable got=%h want=%h", obs, held);
          end
        end
        if (out_ready) begin
          held_valid = 1'b0;
          n_sym++;
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL extra_symbol got=%h want=none", obs);
          end else begin
            exp = exp_q.pop_front();
            if (obs !== exp) begin
              n_fail++;
              $display("FAIL symbol got dc=%0b eob=%0b run=%0d size=%0d amp=%h want dc=%0b eob=%0b run=%0d size=%0d amp=%h",
                       obs[SW-1], obs[SW-2], obs[SW-3:SW-6], obs[SW-7:SW-10], obs[AW-1:0],
                       exp[SW-1], exp[SW-2], exp[SW-3:SW-6], exp[SW-7:SW-10], exp[AW-1:0]);
            end
          end
        end else begin
          held_valid = 1'b1;
          held = obs;
        end
      end else begin
        if (held_valid) begin
          n_cmp++;
          n_fail++;
          $display("FAIL stall_dropped got=out_valid0 want=%h", held);
        end
        held_valid = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int v);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_data = DW'(v);
    do begin
      @(negedge clk);
      guard++;
    end while (!in_ready && guard < 500);
    if (!in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout got=in_ready0 want=1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drive_block(input int c[64], input int gap_odds);
    for (int k = 0; k < 64; k++) begin
      if (gap_odds > 0 && $urandom_range(0, gap_odds - 1) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send(c[k]);
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout got_pending=%0d want=0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    pred_tb = 0;
  endtask

  function automatic int rnd_coef();
    int r;
    int v;
    r = int'($urandom_range(0, 15));
    if (r == 0) return -(1 << (DW - 1));
    if (r == 1) return (1 << (DW - 1)) - 1;
    v = int'($urandom_range(1, (r < 8) ? 3 : (1 << (DW - 1)) - 1));
    return ($urandom_range(0, 1) != 0) ? v : -v;
  endfunction

  task automatic gen_block(output int c[64]);
    int dens;
    dens = int'($urandom_range(0, 3));
    c[0] = int'($urandom_range(0, (1 << DW) - 1)) - (1 << (DW - 1));
    for (int k = 1; k < 64; k++) begin
      case (dens)
        0: c[k] = 0;
        1: c[k] = ($urandom_range(0, 31) == 0) ? rnd_coef() : 0;
        2: c[k] = ($urandom_range(0, 7) == 0) ? rnd_coef() : 0;
        default: c[k] = ($urandom_range(0, 1) == 0) ? rnd_coef() : 0;
      endcase
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_ready got=%b want=0", in_ready);
    end
    n_cmp++;
    if ({out_valid, out_run, out_size, out_amp, out_is_dc, out_eob} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h want=0",
               {out_valid, out_run, out_size, out_amp, out_is_dc, out_eob});
    end
    idle_state = dbg_state;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_in_ready got=%b want=1", in_ready);
    end
    @(posedge clk);
    #1;
    pred_tb = 0;
  endtask

  task automatic test_block_a();
    int c[64];
    int s0;
    rdy_mode = 0;
    for (int k = 0; k < 64; k++) c[k] = 0;
    c[0] = 5;
    exp_q.push_back(mk_sym(1'b1, 1'b0, 0, 3, 5));
    exp_q.push_back(mk_sym(1'b0, 1'b1, 0, 0, 0));
    pred_tb = 5;
    s0 = n_sym;
    drive_block(c, 0);
    drain();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (n_sym - s0 !== 2) begin
      n_fail++;
      $display("FAIL block_a_count got=%0d want=2", n_sym - s0);
    end
  endtask

  task automatic test_block_b();
    int c[64];
    for (int k = 0; k < 64; k++) c[k] = 0;
    c[0] = 3;
    exp_q.push_back(mk_sym(1'b1, 1'b0, 0, 2, 1));  // diff -2
    exp_q.push_back(mk_sym(1'b0, 1'b1, 0, 0, 0));
    drive_block(c, 0);
    exp_q.push_back(mk_sym(1'b1, 1'b0, 0, 0, 0));  // diff 0
    exp_q.push_back(mk_sym(1'b0, 1'b1, 0, 0, 0));
    drive_block(c, 0);
    pred_tb = 3;
    drain();
  endtask

  task automatic test_zrl();
    reset_dut();
    rdy_mode = 0;
    exp_q.push_back(mk_sym(1'b1, 1'b0, 0, 0, 0));
    exp_q.push_back(mk_sym(1'b0, 1'b0, 15, 0, 0));
    exp_q.push_back(mk_sym(1'b0, 1'b0, 4, 1, 0));
    exp_q.push_back(mk_sym(1'b0, 1'b1, 0, 0, 0));
    for (int k = 0; k < 21; k++) send(0);
    send(-1);
    in_valid = 1'b1;
    in_data = '0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL zrl_in_ready_1 got=%b want=0", in_ready);
    end
    n_cmp++;
    if (dbg_state === idle_state) begin
      n_fail++;
      $display("FAIL zrl_state got=%0d want=not_idle", dbg_state);
    end
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL zrl_in_ready_2 got=%b want=0", in_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL zrl_in_ready_3 got=%b want=1", in_ready);
    end
    n_cmp++;
    if (dbg_state !== idle_state) begin
      n_fail++;
      $display("FAIL zrl_return_state got=%0d want=%0d", dbg_state, idle_state);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int k = 23; k < 64; k++) send(0);
    pred_tb = 0;
    drain();
  endtask

  task automatic test_last_nonzero();
    int c[64];
    for (int k = 0; k < 64; k++) c[k] = 0;
    c[63] = 7;
    exp_q.push_back(mk_sym(1'b1, 1'b0, 0, 0, 0));
    repeat (3) exp_q.push_back(mk_sym(1'b0, 1'b0, 15, 0, 0));
    exp_q.push_back(mk_sym(1'b0, 1'b0, 14, 3, 7));
    pred_tb = 0;
    drive_block(c, 0);
    drain();
  endtask

  task automatic test_stall();
    int c[64];
    rdy_mode = 1;
    stall_cnt = 0;
    for (int b = 0; b < 15; b++) begin
      gen_block(c);
      model_block(c);
      drive_block(c, 4);
    end
    drain();
    rdy_mode = 0;
  endtask

  task automatic test_back_to_back();
    int c[64];
    rdy_mode = 2;
    for (int b = 0; b < 1000; b++) begin
      gen_block(c);
      model_block(c);
      drive_block(c, 32);
    end
    drain();
    rdy_mode = 0;
  endtask

  task automatic test_reset_mid();
    int c[64];
    int guard;
    rdy_mode = 0;
    c[0] = 9;
    for (int k = 1; k < 29; k++) c[k] = 1;
    c[29] = 5;
    for (int k = 30; k < 64; k++) c[k] = 0;
    model_block(c);  // leaves (0,3,5) and EOB pending once idx 28 drains
    for (int k = 0; k < 29; k++) send(c[k]);
    guard = 0;
    while (exp_q.size() > 2 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    rdy_mode = 3;
    send(c[29]);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre_valid got=%b want=1", out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, out_run, out_size, out_amp, out_is_dc, out_eob} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs got=%h want=0",
               {out_valid, out_run, out_size, out_amp, out_is_dc, out_eob});
    end
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_in_ready got=%b want=0", in_ready);
    end
    n_cmp++;
    if (exp_q.size() !== 2) begin
      n_fail++;
      $display("FAIL mid_pending got=%0d want=2", exp_q.size());
    end
    exp_q.delete();
    pred_tb = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rdy_mode = 0;
    for (int k = 0; k < 64; k++) c[k] = 0;
    c[0] = 4;
    exp_q.push_back(mk_sym(1'b1, 1'b0, 0, 3, 4));
    exp_q.push_back(mk_sym(1'b0, 1'b1, 0, 0, 0));
    pred_tb = 4;
    drive_block(c, 0);
    drain();
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_block_a();
    test_block_b();
    test_zrl();
    test_last_nonzero();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
